div_unit: RTL and testbench

- Iterative 32-bit integer divider for the execute stage; implements DIV/DIVU and produces the {HI, LO} pair that the HILO path writes in memory stage.
- Drives stall_o, which the hazard unit ORs into stallF/stallD plus an execute hold, keeping the divide instruction in E until the result is ready.
- One quotient bit per cycle, restoring algorithm on magnitudes, sign fix-up at completion.

---
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for the execute stage (DIV/DIVU).
// Produces {HI = remainder, LO = quotient}, one quotient bit per cycle on
// operand magnitudes, with the sign fix-up applied in the DONE cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and
// completes one cycle after start instead of taking the full WIDTH+1 path.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 annul_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   dividend_raw;
    logic               quot_neg;
    logic               rem_neg;
    logic               div_zero;

    logic               start_ok;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               last_step;
    logic [WIDTH-1:0]   quot_final;
    logic [WIDTH-1:0]   rem_final;
    logic [2*WIDTH-1:0] fixed_result;

    // Operand conditioning, one restoring step and the final sign fix-up.
    always_comb begin
        start_ok     = (state == IDLE) && start_i && !annul_i;
        a_neg        = signed_i && a_i[WIDTH-1];
        b_neg        = signed_i && b_i[WIDTH-1];
        a_mag        = a_neg ? (~a_i + ONE) : a_i;
        b_mag        = b_neg ? (~b_i + ONE) : b_i;
        shifted      = {rem, quot[WIDTH-1]};
        diff         = shifted - {1'b0, divisor};
        last_step    = (count == CNT_W'(WIDTH - 1));
        quot_final   = quot_neg ? (~quot + ONE) : quot;
        rem_final    = rem_neg ? (~rem + ONE) : rem;
        fixed_result = div_zero ? {dividend_raw, {WIDTH{1'b1}}}
                                : {rem_final, quot_final};
    end

    // Stall covers the start cycle and every iteration; DONE lets the instruction go.
    always_comb begin
        stall_o = start_ok || (state == BUSY);
        ready_o = (state == DONE) && !annul_i;
    end

    // Control FSM and datapath registers; annul returns to IDLE from any state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            count        <= '0;
            quot         <= '0;
            rem          <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            quot_neg     <= 1'b0;
            rem_neg      <= 1'b0;
            div_zero     <= 1'b0;
            result_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        quot         <= a_mag;
                        rem          <= '0;
                        divisor      <= b_mag;
                        dividend_raw <= a_i;
                        quot_neg     <= a_neg ^ b_neg;
                        rem_neg      <= a_neg;
                        div_zero     <= (b_i == '0);
                        count        <= '0;
`ifdef DIV_ZERO_FAST_EN
                        state        <= (b_i == '0) ? DONE : BUSY;
`else
                        state        <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        if (!diff[WIDTH]) begin
                            rem  <= diff[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= shifted[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                        count <= count + CNT_W'(1);
                        if (last_step) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!annul_i) begin
                        result_o <= fixed_result;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit with a behavioural divide model.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic              clk;
    logic              resetn;
    logic              start_i;
    logic              signed_i;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic              annul_i;
    logic              stall_o;
    logic              ready_o;
    logic [2*WIDTH-1:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_result = 64'd0;

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: HI = remainder, LO = quotient, truncating division.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int expected_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return WIDTH + 1;
    endfunction

    task automatic test_reset();
        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        annul_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
        n_checks++;
        if (result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // One complete divide with start held while stalled; operands are
    // scrambled after the start cycle to show they are not re-sampled.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [63:0] exp_res;
        int exp_rdy;
        int rdy_cyc;
        int stall_cnt;
        exp_res   = model(sgn, a, b);
        exp_rdy   = expected_latency(b);
        rdy_cyc   = -1;
        stall_cnt = 0;
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = sgn;
        a_i      = a;
        b_i      = b;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (stall_o === 1'b1) stall_cnt++;
            if (ready_o === 1'b1) begin
                rdy_cyc = c;
                break;
            end
            @(posedge clk); #1;
            a_i      = $urandom;
            b_i      = $urandom;
            signed_i = 1'($urandom_range(0, 1));
        end
        n_checks++;
        if (rdy_cyc != exp_rdy) begin
            n_fail++;
            $display("[TB] FAIL %s_ready_cycle: got %0d expected %0d", name, rdy_cyc, exp_rdy);
        end
        n_checks++;
        if (stall_cnt != exp_rdy) begin
            n_fail++;
            $display("[TB] FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, exp_rdy);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (result_o !== exp_res) begin
            n_fail++;
            $display("[TB] FAIL %s_result: got %h expected %h", name, result_o, exp_res);
        end
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_ready_pulse: got %b expected 0", name, ready_o);
        end
        last_result = exp_res;
    endtask

    task automatic test_directed();
        do_div(1'b0, 32'd100, 32'd7, "udiv_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, "sdiv_m7_2");
        do_div(1'b1, 32'h7, 32'hFFFF_FFFE, "sdiv_7_m2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "udiv_ovf");
        do_div(1'b0, 32'd5, 32'd0, "udiv_zero");
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, "sdiv_zero");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            do_div(1'($urandom_range(0, 1)), a, b, "random");
        end
    endtask

    task automatic test_annul();
        int bad_stall;
        int bad_ready;
        bad_stall = 0;
        bad_ready = 0;
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'h1234_5678;
        b_i      = 32'h11;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        annul_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_o !== 1'b1) begin n_fail++; $display("[TB] FAIL annul_c10_stall: got %b expected 1", stall_o); end
        @(posedge clk); #1;
        annul_i = 1'b0;
        for (int c = 11; c < 45; c++) begin
            @(negedge clk);
            if (stall_o !== 1'b0) bad_stall++;
            if (ready_o !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_stall != 0) begin n_fail++; $display("[TB] FAIL annul_stall_after: got %0d stalled cycles expected 0", bad_stall); end
        n_checks++;
        if (bad_ready != 0) begin n_fail++; $display("[TB] FAIL annul_no_ready: got %0d ready cycles expected 0", bad_ready); end
        n_checks++;
        if (result_o !== last_result) begin n_fail++; $display("[TB] FAIL annul_result_kept: got %h expected %h", result_o, last_result); end
        do_div(1'b0, 32'd9, 32'd3, "after_annul");

        // start and annul together in IDLE must not begin a divide
        @(posedge clk); #1;
        start_i = 1'b1;
        annul_i = 1'b1;
        a_i     = 32'd50;
        b_i     = 32'd5;
        @(negedge clk);
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("[TB] FAIL start_annul_stall: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        bad_stall = 0;
        bad_ready = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall_o !== 1'b0) bad_stall++;
            if (ready_o !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_stall + bad_ready != 0) begin
            n_fail++;
            $display("[TB] FAIL start_annul_idle: got %0d active cycles expected 0", bad_stall + bad_ready);
        end
    endtask

    // Annul landing on the DONE cycle must suppress ready and the result write.
    task automatic test_annul_done();
        int lat;
        lat = expected_latency(32'd4);
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd1000;
        b_i      = 32'd4;
        for (int c = 0; c < lat; c++) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL annul_done_ready: got %b expected 0", ready_o); end
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (result_o !== last_result) begin n_fail++; $display("[TB] FAIL annul_done_result: got %h expected %h", result_o, last_result); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start_i  = 1'b1;
        signed_i = 1'b1;
        a_i      = 32'd77;
        b_i      = 32'd3;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        resetn  = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_stall: got %b expected 0", stall_o); end
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_ready: got %b expected 0", ready_o); end
        n_checks++;
        if (result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL midreset_result: got %h expected 0", result_o); end
        @(posedge clk); #1;
        resetn = 1'b1;
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_annul_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
